// File: rtl/cvs_pkg.sv
// Shared sizes and types for the capacitor-voltage sorter: FSM states and the
// (voltage, submodule index) pair that travels through the sorting network.
package cvs_pkg;

  localparam int N_SM  = 5;
  localparam int VW    = 12;
  localparam int IDX_W = $clog2(N_SM + 1);
  localparam int N_CMP = N_SM / 2;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    SELECT
  } state_t;

  typedef struct packed {
    logic [VW-1:0]    val;
    logic [IDX_W-1:0] idx;
  } sort_pair_t;

endpackage

// File: rtl/cvs_cmp_swap.sv
// Combinational compare-exchange of two (voltage, index) pairs. Swaps only on a
// strict greater-than so equal voltages never change relative order.
module cvs_cmp_swap
  import cvs_pkg::*;
(
  input  sort_pair_t a,
  input  sort_pair_t b,
  output sort_pair_t lo,
  output sort_pair_t hi
);

  logic swap;

  assign swap = (a.val > b.val);
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/cap_volt_sort_select.sv
// MMC arm capacitor-voltage sorter: odd-even transposition sort (one phase per
// cycle) followed by insertion-mask selection of the lowest/highest n_on submodules.
module cap_volt_sort_select
  import cvs_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_SM*VW-1:0]   v_cap,
  input  logic [IDX_W-1:0]     n_on,
  input  logic                 i_arm_pos,
  output logic                 busy,
  output logic                 done,
  output logic [N_SM-1:0]      ins_mask,
  output logic [IDX_W-1:0]     n_ins,
  output logic                 n_clamped
);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  phase_q, phase_d;
  sort_pair_t        pair_q [N_SM];
  sort_pair_t        pair_d [N_SM];
  logic [IDX_W-1:0]  n_on_q, n_on_d;
  logic              pos_q, pos_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_SM-1:0]   ins_mask_q, ins_mask_d;
  logic [IDX_W-1:0]  n_ins_q, n_ins_d;
  logic              n_clamped_q, n_clamped_d;

  sort_pair_t        cmp_a  [N_CMP];
  sort_pair_t        cmp_b  [N_CMP];
  sort_pair_t        cmp_lo [N_CMP];
  sort_pair_t        cmp_hi [N_CMP];

  logic [IDX_W-1:0]  n_eff;
  logic [N_SM-1:0]   mask_sel;

  // Comparator j serves pair (2j,2j+1) on even phases and (2j+1,2j+2) on odd ones.
  for (genvar j = 0; j < N_CMP; j++) begin : g_cmp
    if (2*j + 2 < N_SM) begin : g_mux
      assign cmp_a[j] = phase_q[0] ? pair_q[2*j+1] : pair_q[2*j];
      assign cmp_b[j] = phase_q[0] ? pair_q[2*j+2] : pair_q[2*j+1];
    end else begin : g_even_only
      assign cmp_a[j] = pair_q[2*j];
      assign cmp_b[j] = pair_q[2*j+1];
    end
    cvs_cmp_swap u_cmp (
      .a  (cmp_a[j]),
      .b  (cmp_b[j]),
      .lo (cmp_lo[j]),
      .hi (cmp_hi[j])
    );
  end

  // Rank r is selected from the bottom when charging, from the top when discharging.
  always_comb begin
    n_eff    = (n_on_q > IDX_W'(N_SM)) ? IDX_W'(N_SM) : n_on_q;
    mask_sel = '0;
    for (int r = 0; r < N_SM; r++) begin
      if (pos_q ? (r < int'(n_eff)) : (r >= N_SM - int'(n_eff)))
        mask_sel[pair_q[r].idx] = 1'b1;
    end
  end

  // NOTE: every _d gets a default from its _q first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    pair_d      = pair_q;
    n_on_d      = n_on_q;
    pos_d       = pos_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ins_mask_d  = ins_mask_q;
    n_ins_d     = n_ins_q;
    n_clamped_d = n_clamped_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          for (int k = 0; k < N_SM; k++) begin
            pair_d[k].val = v_cap[k*VW +: VW];
            pair_d[k].idx = IDX_W'(k);
          end
          n_on_d  = n_on;
          pos_d   = i_arm_pos;
          phase_d = '0;
          busy_d  = 1'b1;
          state_d = SORT;
        end
      end
      SORT: begin
        for (int j = 0; j < N_CMP; j++) begin
          if (!phase_q[0]) begin
            pair_d[2*j]   = cmp_lo[j];
            pair_d[2*j+1] = cmp_hi[j];
          end else if (2*j + 2 < N_SM) begin
            pair_d[2*j+1] = cmp_lo[j];
            pair_d[2*j+2] = cmp_hi[j];
          end
        end
        phase_d = phase_q + 1'b1;
        if (phase_q == IDX_W'(N_SM - 1))
          state_d = SELECT;
      end
      SELECT: begin
        ins_mask_d  = mask_sel;
        n_ins_d     = n_eff;
        n_clamped_d = (n_on_q > IDX_W'(N_SM));
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      n_on_q      <= '0;
      pos_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ins_mask_q  <= '0;
      n_ins_q     <= '0;
      n_clamped_q <= 1'b0;
      // NOTE: the pair file is small and must come out of reset cleared, so it is
      // reset explicitly rather than left to be overwritten by the next capture.
      for (int k = 0; k < N_SM; k++)
        pair_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      pair_q      <= pair_d;
      n_on_q      <= n_on_d;
      pos_q       <= pos_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ins_mask_q  <= ins_mask_d;
      n_ins_q     <= n_ins_d;
      n_clamped_q <= n_clamped_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ins_mask  = ins_mask_q;
  assign n_ins     = n_ins_q;
  assign n_clamped = n_clamped_q;

endmodule

// File: tb/tb_cap_volt_sort_select.sv
// Scoreboard bench for cap_volt_sort_select: stimulus pushes hand-computed results,
// a negedge monitor pops and compares them (including done timing) on every done.
module tb_cap_volt_sort_select;
  import cvs_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [N_SM*VW-1:0] v_cap;
  logic [IDX_W-1:0]   n_on;
  logic               i_arm_pos;
  logic               busy;
  logic               done;
  logic [N_SM-1:0]    ins_mask;
  logic [IDX_W-1:0]   n_ins;
  logic               n_clamped;

  cap_volt_sort_select dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .v_cap     (v_cap),
    .n_on      (n_on),
    .i_arm_pos (i_arm_pos),
    .busy      (busy),
    .done      (done),
    .ins_mask  (ins_mask),
    .n_ins     (n_ins),
    .n_clamped (n_clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_SM-1:0]  mask;
    logic [IDX_W-1:0] nins;
    logic             clamp;
    int               at_edge;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at edge %0d",
               name, act, act, exp, exp, edge_cnt);
    end
  endtask

  function automatic logic [N_SM*VW-1:0] pack5(input int a0, a1, a2, a3, a4);
    logic [N_SM*VW-1:0] p;
    p = '0;
    p[0*VW +: VW] = VW'(a0);
    p[1*VW +: VW] = VW'(a1);
    p[2*VW +: VW] = VW'(a2);
    p[3*VW +: VW] = VW'(a3);
    p[4*VW +: VW] = VW'(a4);
    return p;
  endfunction

  // Monitor: every done must match the oldest expected entry, on the expected edge.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no done at edge %0d", edge_cnt);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("ins_mask",  32'(ins_mask),  32'(e.mask));
        check("n_ins",     32'(n_ins),     32'(e.nins));
        check("n_clamped", 32'(n_clamped), 32'(e.clamp));
        check("done_edge", 32'(edge_cnt),  32'(e.at_edge));
        check("popcount",  32'($countones(ins_mask)), 32'(n_ins));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Caller sits on a negedge; the next posedge is E0 and done shows after E0+6.
  task automatic issue(input logic [N_SM*VW-1:0] v, input int n, input logic pos,
                       input logic [N_SM-1:0] m, input int ni, input logic cl,
                       input logic expect_done);
    exp_t e;
    v_cap     = v;
    n_on      = IDX_W'(n);
    i_arm_pos = pos;
    start     = 1'b1;
    if (expect_done) begin
      e.mask    = m;
      e.nins    = IDX_W'(ni);
      e.clamp   = cl;
      e.at_edge = edge_cnt + 1 + N_SM + 1;
      q.push_back(e);
    end
    @(negedge clk);
    start     = 1'b0;
    v_cap     = pack5(4095, 4095, 0, 0, 4095);
    n_on      = IDX_W'(1);
    i_arm_pos = ~pos;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && (q.size() != 0 || busy); i++) @(negedge clk);
    check(name, 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [N_SM*VW-1:0] v, input int n, input logic pos,
                     input logic [N_SM-1:0] m, input int ni, input logic cl, input string name);
    issue(v, n, pos, m, ni, cl, 1'b1);
    drain(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_SM*VW-1:0] v1, vrev, vtie, vmax;
    bit seen;
    v1   = pack5(100, 400, 200, 500, 300);
    vrev = pack5(300, 500, 200, 400, 100);
    vtie = pack5(250, 250, 250, 250, 250);
    vmax = pack5(4095, 0, 4095, 100, 4095);

    rst = 1'b1; start = 1'b0; v_cap = '0; n_on = '0; i_arm_pos = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_mask",      32'(ins_mask),  32'd0);
    check("rst_n_ins",     32'(n_ins),     32'd0);
    check("rst_n_clamped", 32'(n_clamped), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(v1,   2, 1'b1, 5'b00101, 2, 1'b0, "drain_charge");
    run(v1,   2, 1'b0, 5'b01010, 2, 1'b0, "drain_discharge");
    run(vtie, 3, 1'b1, 5'b00111, 3, 1'b0, "drain_tie_charge");
    run(vtie, 3, 1'b0, 5'b11100, 3, 1'b0, "drain_tie_discharge");
    run(vmax, 2, 1'b0, 5'b10100, 2, 1'b0, "drain_maxval");
    run(v1,   0, 1'b1, 5'b00000, 0, 1'b0, "drain_n0");

    // Start held through the whole sort, inputs wiggling after capture.
    begin
      exp_t e;
      v_cap = v1; n_on = IDX_W'(2); i_arm_pos = 1'b1; start = 1'b1;
      e.mask = 5'b00101; e.nins = IDX_W'(2); e.clamp = 1'b0;
      e.at_edge = edge_cnt + 1 + N_SM + 1;
      q.push_back(e);
      for (int i = 0; i < N_SM + 2; i++) begin
        @(negedge clk);
        v_cap = pack5(i, 4000 - i, 7, 3000, i * 9);
        n_on  = IDX_W'(i % 6);
        i_arm_pos = i[0];
      end
      start = 1'b0;
      drain("drain_hold_start");
    end

    // Back-to-back: start again on the done cycle with reversed voltages.
    issue(v1, 2, 1'b1, 5'b00101, 2, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check("b2b_first_done_seen", 32'(seen), 32'd1);
    issue(vrev, 2, 1'b1, 5'b10100, 2, 1'b0, 1'b1);
    drain("drain_b2b");

    // Clamp case; n_clamped must persist after done.
    run(v1, 7, 1'b1, 5'b11111, 5, 1'b1, "drain_n7");
    check("clamp_held", 32'(n_clamped), 32'd1);
    check("mask_held",  32'(ins_mask),  32'h1f);

    // Reset mid-sort: sampled at E0+3, no done, outputs cleared.
    issue(v1, 2, 1'b0, '0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_done",      32'(done),      32'd0);
    check("abort_mask",      32'(ins_mask),  32'd0);
    check("abort_n_ins",     32'(n_ins),     32'd0);
    check("abort_n_clamped", 32'(n_clamped), 32'd0);
    repeat (10) @(negedge clk);
    run(v1, 2, 1'b0, 5'b01010, 2, 1'b0, "drain_after_abort");

    check("final_queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
